// File: rtl/aes_pnm_controller.sv
// aes_pnm_controller: control sequencer for the FeRAM near-memory AES datapath (load, rounds, write-back).
// Optional macro AES_PNM_DONE_STICKY_EN holds done high until the next accepted start.
module aes_pnm_controller #(
    parameter int N_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       enc_dec,
    output logic       done,
    output logic       sra_en,
    output logic [3:0] row_addr,
    output logic       mem_wr_en,
    output logic [3:0] mem_wr_row,
    output logic       pe_en,
    output logic [1:0] op_sel,
    output logic       load_psum,
    output logic       shift_in_en,
    output logic [3:0] round,
    output logic       subbytes_sel,
    output logic       shiftrows_sel
);
    if (N_ROUNDS < 2 || N_ROUNDS > 15) begin : g_bad_rounds
        $error("N_ROUNDS must be in 2..15");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARK, S_SUB, S_SHF, S_MIX, S_WB, S_DONE
    } state_t;

    localparam logic [3:0] LP_N = 4'(N_ROUNDS);

    state_t     r_state, w_next;
    logic [1:0] r_cnt, w_cnt;
    logic [3:0] r_round, w_round;
    logic       r_enc, w_enc, w_last;
    logic       r_done, r_sra_en, r_mem_wr_en, r_pe_en, r_load_psum;
    logic       r_shift_in_en, r_sub, r_shf;
    logic [3:0] r_row_addr, r_mem_wr_row;
    logic [1:0] r_op_sel;

    assign w_last = (r_cnt == 2'd3);

    always_comb begin
        w_next  = r_state;
        w_round = r_round;
        w_enc   = r_enc;
        case (r_state)
            S_IDLE: if (start) begin
                w_next  = S_LOAD;
                w_round = 4'd0;
                w_enc   = enc_dec;
            end
            S_LOAD: if (w_last) w_next = S_ARK;
            // Decrypt runs MIX after ARK, so only the initial ARK advances the round there.
            S_ARK: if (w_last) begin
                if (r_round == LP_N) w_next = S_WB;
                else if (r_enc || r_round == 4'd0) begin
                    w_round = r_round + 4'd1;
                    w_next  = r_enc ? S_SUB : S_SHF;
                end
                else w_next = S_MIX;
            end
            S_SUB: w_next = r_enc ? S_SHF : S_ARK;
            S_SHF: w_next = r_enc ? ((r_round == LP_N) ? S_ARK : S_MIX) : S_SUB;
            S_MIX: if (w_last) begin
                if (r_enc) w_next = S_ARK;
                else begin
                    w_round = r_round + 4'd1;
                    w_next  = S_SHF;
                end
            end
            S_WB:   if (w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_cnt = (w_next != r_state || r_state == S_IDLE) ? 2'd0 : r_cnt + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_round       <= 4'd0;
            r_enc         <= 1'b0;
            r_done        <= 1'b0;
            r_sra_en      <= 1'b0;
            r_row_addr    <= 4'd0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_row  <= 4'd0;
            r_pe_en       <= 1'b0;
            r_op_sel      <= 2'b00;
            r_load_psum   <= 1'b0;
            r_shift_in_en <= 1'b0;
            r_sub         <= 1'b0;
            r_shf         <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt;
            r_round       <= w_round;
            r_enc         <= w_enc;
            r_sra_en      <= (w_next == S_LOAD) || (w_next == S_ARK);
            r_row_addr    <= (w_next == S_LOAD) ? {2'b00, w_cnt} :
                             (w_next == S_ARK)  ? {2'b01, w_cnt} : 4'd0;
            r_mem_wr_en   <= (w_next == S_WB);
            r_mem_wr_row  <= (w_next == S_WB) ? {2'b10, w_cnt} : 4'd0;
            r_pe_en       <= (w_next == S_ARK) || (w_next == S_SUB) ||
                             (w_next == S_SHF) || (w_next == S_MIX);
            r_op_sel      <= (w_next == S_ARK) ? 2'b01 :
                             (w_next == S_MIX) ? (w_enc ? 2'b10 : 2'b11) :
                             (w_next == S_SUB || w_next == S_SHF) ? (w_enc ? 2'b00 : 2'b11) : 2'b00;
            r_load_psum   <= (w_next == S_ARK);
            r_shift_in_en <= (w_next == S_LOAD);
            r_sub         <= (w_next == S_SUB);
            r_shf         <= (w_next == S_SHF);
`ifdef AES_PNM_DONE_STICKY_EN
            r_done        <= (w_next == S_DONE) || (r_done && !(r_state == S_IDLE && start));
`else
            r_done        <= (w_next == S_DONE);
`endif
        end
    end

    assign done          = r_done;
    assign sra_en        = r_sra_en;
    assign row_addr      = r_row_addr;
    assign mem_wr_en     = r_mem_wr_en;
    assign mem_wr_row    = r_mem_wr_row;
    assign pe_en         = r_pe_en;
    assign op_sel        = r_op_sel;
    assign load_psum     = r_load_psum;
    assign shift_in_en   = r_shift_in_en;
    assign round         = r_round;
    assign subbytes_sel  = r_sub;
    assign shiftrows_sel = r_shf;
endmodule

// File: tb/tb_aes_pnm_controller.sv
// tb_aes_pnm_controller: scoreboard bench; stimulus queues timed expected control vectors, a monitor checks them.
module tb_aes_pnm_controller;
    logic clk = 0, rst_n = 0, start = 0, start_b = 0, enc_dec = 0;
    logic done, sra_en, mem_wr_en, pe_en, load_psum, shift_in_en, subbytes_sel, shiftrows_sel;
    logic [3:0] row_addr, mem_wr_row, round;
    logic [1:0] op_sel;
    logic done_b, sra_en_b, mem_wr_en_b, pe_en_b, load_psum_b, shift_in_en_b, subbytes_sel_b, shiftrows_sel_b;
    logic [3:0] row_addr_b, mem_wr_row_b, round_b;
    logic [1:0] op_sel_b;

    aes_pnm_controller #(.N_ROUNDS(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .enc_dec(enc_dec), .done(done),
        .sra_en(sra_en), .row_addr(row_addr), .mem_wr_en(mem_wr_en), .mem_wr_row(mem_wr_row),
        .pe_en(pe_en), .op_sel(op_sel), .load_psum(load_psum), .shift_in_en(shift_in_en),
        .round(round), .subbytes_sel(subbytes_sel), .shiftrows_sel(shiftrows_sel));

    aes_pnm_controller #(.N_ROUNDS(14)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .enc_dec(enc_dec), .done(done_b),
        .sra_en(sra_en_b), .row_addr(row_addr_b), .mem_wr_en(mem_wr_en_b), .mem_wr_row(mem_wr_row_b),
        .pe_en(pe_en_b), .op_sel(op_sel_b), .load_psum(load_psum_b), .shift_in_en(shift_in_en_b),
        .round(round_b), .subbytes_sel(subbytes_sel_b), .shiftrows_sel(shiftrows_sel_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {sra,row,wr,wrow,pe,op,lp,sh,round,sub,shf,done}
    logic [21:0] vec [2];
    assign vec[0] = {sra_en, row_addr, mem_wr_en, mem_wr_row, pe_en, op_sel, load_psum,
                     shift_in_en, round, subbytes_sel, shiftrows_sel, done};
    assign vec[1] = {sra_en_b, row_addr_b, mem_wr_en_b, mem_wr_row_b, pe_en_b, op_sel_b, load_psum_b,
                     shift_in_en_b, round_b, subbytes_sel_b, shiftrows_sel_b, done_b};

    typedef struct {int inst; int cyc; logic [21:0] v;} exp_t;
    exp_t q[$];
    int errors = 0, checks = 0, base = 0;

    function automatic logic [21:0] mk(logic sra, logic [3:0] row, logic wr, logic [3:0] wrow,
                                       logic pe, logic [1:0] op, logic lp, logic sh,
                                       logic [3:0] rnd, logic sub, logic shf, logic dn);
        return {sra, row, wr, wrow, pe, op, lp, sh, rnd, sub, shf, dn};
    endfunction

    task automatic push(input int inst, inout int k, input logic [21:0] v);
        exp_t e;
        e.inst = inst; e.cyc = k; e.v = v;
        q.push_back(e);
        k++;
    endtask

    task automatic p_ark(input int inst, inout int k, input int r);
        for (int i = 0; i < 4; i++) push(inst, k, mk(1, 4'(4 + i), 0, 0, 1, 2'b01, 1, 0, 4'(r), 0, 0, 0));
    endtask

    task automatic p_mix(input int inst, inout int k, input int r, input logic enc);
        for (int i = 0; i < 4; i++) push(inst, k, mk(0, 0, 0, 0, 1, enc ? 2'b10 : 2'b11, 0, 0, 4'(r), 0, 0, 0));
    endtask

    task automatic p_sub(input int inst, inout int k, input int r, input logic enc);
        push(inst, k, mk(0, 0, 0, 0, 1, enc ? 2'b00 : 2'b11, 0, 0, 4'(r), 1, 0, 0));
    endtask

    task automatic p_shf(input int inst, inout int k, input int r, input logic enc);
        push(inst, k, mk(0, 0, 0, 0, 1, enc ? 2'b00 : 2'b11, 0, 0, 4'(r), 0, 1, 0));
    endtask

    task automatic model(input int inst, input int n, input logic enc, input int b);
        int k;
        k = b;
        for (int i = 0; i < 4; i++) push(inst, k, mk(1, 4'(i), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        p_ark(inst, k, 0);
        for (int r = 1; r <= n; r++) begin
            if (enc) begin
                p_sub(inst, k, r, enc);
                p_shf(inst, k, r, enc);
                if (r < n) p_mix(inst, k, r, enc);
                p_ark(inst, k, r);
            end else begin
                p_shf(inst, k, r, enc);
                p_sub(inst, k, r, enc);
                p_ark(inst, k, r);
                if (r < n) p_mix(inst, k, r, enc);
            end
        end
        for (int i = 0; i < 4; i++) push(inst, k, mk(0, 0, 1, 4'(8 + i), 0, 0, 0, 0, 4'(n), 0, 0, 0));
        push(inst, k, mk(0, 0, 0, 0, 0, 0, 0, 0, 4'(n), 0, 0, 1));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (vec[i][21] | vec[i][16] | vec[i][11] | vec[i][7] | vec[i][0]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output inst=%0d cyc=%0d got=%h expected none", i, cyc, vec[i]);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.inst != i || e.cyc != cyc || e.v != vec[i]) begin
                        errors++;
                        $display("FAIL seq got inst=%0d cyc=%0d v=%h expected inst=%0d cyc=%0d v=%h",
                                 i, cyc, vec[i], e.inst, e.cyc, e.v);
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", n, got, exp);
        end
    endtask

    task automatic run(input int inst, input logic enc);
        @(negedge clk);
        enc_dec = enc;
        if (inst == 0) start = 1; else start_b = 1;
        @(posedge clk);
        #1;
        base = cyc;
        start = 0; start_b = 0;
        enc_dec = ~enc;
        model(inst, inst == 0 ? 10 : 14, enc, base);
    endtask

    task automatic drain(input string n);
        int t;
        t = 0;
        while (q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got pending=%0d expected pending=0", n, q.size());
            q.delete();
        end
    endtask

    initial begin
        #12;
        chk("reset_vec0", int'(vec[0]), 0);
        chk("reset_vec1", int'(vec[1]), 0);
        @(negedge clk) rst_n = 1;
        repeat (2) @(negedge clk);
        run(0, 1);
        drain("enc");
        repeat (3) @(negedge clk);
        chk("round_hold_enc", int'(round), 10);
        chk("done_pulse", int'(done), 0);
        run(0, 0);
        repeat (20) @(negedge clk);
        start = 1;
        @(negedge clk) start = 0;
        drain("dec");
        repeat (2) @(negedge clk);
        chk("round_hold_dec", int'(round), 10);
        run(0, 1);
        while (cyc < base + 108) @(negedge clk);
        start = 1;
        @(negedge clk) start = 0;
        drain("enc_rerun");
        repeat (5) @(negedge clk);
        chk("start_in_done_ignored", int'(round), 10);
        run(0, 1);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 0;
        q.delete();
        #1;
        chk("midreset_vec0", int'(vec[0]), 0);
        chk("midreset_round", int'(round), 0);
        @(negedge clk) rst_n = 1;
        run(0, 0);
        drain("after_reset");
        run(1, 1);
        drain("n14");
        repeat (2) @(negedge clk);
        chk("round_hold_n14", int'(round_b), 14);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
